aludec_pipe: RTL



---
 rtl/aludec_pipe_if.sv | 30 +++
 rtl/aludec_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aludec_pipe_if.sv
// Purpose: bundles the decoder/pipeline handshake and bus signals of aludec_pipe.
// Latency: none, wiring only.
// Backpressure: carries stall/flush into the pipe and md_stall_req back to the hazard unit.
interface aludec_pipe_if #(
   parameter int ALUOP_W = 8,
   parameter int STAGES  = 2
);
   logic [31:0]               instrD;
   logic                      validD;
   logic [STAGES-1:0]         stall;
   logic [STAGES-1:0]         flush;
   logic                      md_done;
   logic [STAGES*ALUOP_W-1:0] aluop_out;
   logic [STAGES-1:0]         ri_out;
   logic                      md_start;
   logic                      md_cancel;
   logic                      md_stall_req;

   // upstream side: main decoder, hazard unit and MD unit drive the inputs
   modport master (
      output instrD, validD, stall, flush, md_done,
      input  aluop_out, ri_out, md_start, md_cancel, md_stall_req
   );

   // the decoder pipe itself
   modport slave (
      input  instrD, validD, stall, flush, md_done,
      output aluop_out, ri_out, md_start, md_cancel, md_stall_req
   );
endinterface

// File: rtl/aludec_pipe.sv
// Purpose: decodes the D-stage instruction into an ALU op, carries {op,ri,md} through STAGES registers, runs the MD start/stall handshake.
// Latency: decode is combinational; stage k output shows the instruction k+1 cycles after it sat in instrD.
// Backpressure: stall[k] holds stage k, stall[k-1] bubbles stage k, flush wins over stall; md_stall_req holds D and stage 0 while MD is busy.
module aludec_pipe #(
   parameter int ALUOP_W = 8,
   parameter int STAGES  = 2,
   parameter int RI_EN   = 1
) (
   input  logic         clk,
   input  logic         rst,
   aludec_pipe_if.slave bus
);

   localparam logic [7:0] ALUOP_AND   = 8'h01;
   localparam logic [7:0] ALUOP_OR    = 8'h02;
   localparam logic [7:0] ALUOP_XOR   = 8'h03;
   localparam logic [7:0] ALUOP_NOR   = 8'h04;
   localparam logic [7:0] ALUOP_SLT   = 8'h05;
   localparam logic [7:0] ALUOP_SLTU  = 8'h06;
   localparam logic [7:0] ALUOP_ADD   = 8'h07;
   localparam logic [7:0] ALUOP_ADDU  = 8'h08;
   localparam logic [7:0] ALUOP_SUB   = 8'h09;
   localparam logic [7:0] ALUOP_SUBU  = 8'h0A;
   localparam logic [7:0] ALUOP_SLL   = 8'h0B;
   localparam logic [7:0] ALUOP_SLLV  = 8'h0C;
   localparam logic [7:0] ALUOP_SRL   = 8'h0D;
   localparam logic [7:0] ALUOP_SRLV  = 8'h0E;
   localparam logic [7:0] ALUOP_SRA   = 8'h0F;
   localparam logic [7:0] ALUOP_SRAV  = 8'h10;
   localparam logic [7:0] ALUOP_MULT  = 8'h11;
   localparam logic [7:0] ALUOP_MULTU = 8'h12;
   localparam logic [7:0] ALUOP_DIV   = 8'h13;
   localparam logic [7:0] ALUOP_DIVU  = 8'h14;
   localparam logic [7:0] ALUOP_MFHI  = 8'h15;
   localparam logic [7:0] ALUOP_MFLO  = 8'h16;
   localparam logic [7:0] ALUOP_MTHI  = 8'h17;
   localparam logic [7:0] ALUOP_MTLO  = 8'h18;
   localparam logic [7:0] ALUOP_ANDI  = 8'h19;
   localparam logic [7:0] ALUOP_XORI  = 8'h1A;
   localparam logic [7:0] ALUOP_ORI   = 8'h1B;
   localparam logic [7:0] ALUOP_LUI   = 8'h1C;
   localparam logic [7:0] ALUOP_ADDI  = 8'h1D;
   localparam logic [7:0] ALUOP_ADDIU = 8'h1E;
   localparam logic [7:0] ALUOP_SLTI  = 8'h1F;
   localparam logic [7:0] ALUOP_SLTIU = 8'h20;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

   logic [5:0]         opc;
   logic [5:0]         funct;
   logic [7:0]         dec_op8;
   logic               dec_ri_raw;
   logic               dec_md;
   logic [ALUOP_W-1:0] dec_op;
   logic               dec_ri;
   logic               unused_instr_bits;

   logic [STAGES-1:0][ALUOP_W-1:0] op_q;
   logic [STAGES-1:0][ALUOP_W-1:0] op_in;
   logic [STAGES-1:0]              ri_q, md_q, ri_in, md_in, bubble;

   md_state_t state_q, state_d;
   logic      md_start, md_cancel, md_stall_req;

   assign opc               = bus.instrD[31:26];
   assign funct             = bus.instrD[5:0];
   assign unused_instr_bits = ^bus.instrD[24:6];

   // instruction decode: ALU op, reserved-instruction flag, MD flag
   always_comb begin
      dec_op8    = '0;
      dec_ri_raw = 1'b0;
      dec_md     = 1'b0;
      if (bus.validD) begin
         case (opc)
            6'h00: begin
               case (funct)
                  6'h00: dec_op8 = ALUOP_SLL;
                  6'h02: dec_op8 = ALUOP_SRL;
                  6'h03: dec_op8 = ALUOP_SRA;
                  6'h04: dec_op8 = ALUOP_SLLV;
                  6'h06: dec_op8 = ALUOP_SRLV;
                  6'h07: dec_op8 = ALUOP_SRAV;
                  6'h10: dec_op8 = ALUOP_MFHI;
                  6'h11: dec_op8 = ALUOP_MTHI;
                  6'h12: dec_op8 = ALUOP_MFLO;
                  6'h13: dec_op8 = ALUOP_MTLO;
                  6'h18: begin dec_op8 = ALUOP_MULT;  dec_md = 1'b1; end
                  6'h19: begin dec_op8 = ALUOP_MULTU; dec_md = 1'b1; end
                  6'h1A: begin dec_op8 = ALUOP_DIV;   dec_md = 1'b1; end
                  6'h1B: begin dec_op8 = ALUOP_DIVU;  dec_md = 1'b1; end
                  6'h20: dec_op8 = ALUOP_ADD;
                  6'h21: dec_op8 = ALUOP_ADDU;
                  6'h22: dec_op8 = ALUOP_SUB;
                  6'h23: dec_op8 = ALUOP_SUBU;
                  6'h24: dec_op8 = ALUOP_AND;
                  6'h25: dec_op8 = ALUOP_OR;
                  6'h26: dec_op8 = ALUOP_XOR;
                  6'h27: dec_op8 = ALUOP_NOR;
                  6'h2A: dec_op8 = ALUOP_SLT;
                  6'h2B: dec_op8 = ALUOP_SLTU;
                  // JR, JALR, SYSCALL, BREAK: legal, no ALU work
                  6'h08, 6'h09, 6'h0C, 6'h0D: dec_op8 = '0;
                  default: dec_ri_raw = 1'b1;
               endcase
            end
            // REGIMM branches, J, JAL, BEQ, BNE, BLEZ, BGTZ
            6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: dec_op8 = '0;
            6'h08: dec_op8 = ALUOP_ADDI;
            6'h09: dec_op8 = ALUOP_ADDIU;
            6'h0A: dec_op8 = ALUOP_SLTI;
            6'h0B: dec_op8 = ALUOP_SLTIU;
            6'h0C: dec_op8 = ALUOP_ANDI;
            6'h0D: dec_op8 = ALUOP_ORI;
            6'h0E: dec_op8 = ALUOP_XORI;
            6'h0F: dec_op8 = ALUOP_LUI;
            // COP0: only ERET is supported
            6'h10: dec_ri_raw = !(bus.instrD[25] && (funct == 6'h18));
            // loads and stores use the adder for the effective address
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: dec_op8 = ALUOP_ADDU;
            default: dec_ri_raw = 1'b1;
         endcase
      end
   end

   assign dec_op = ALUOP_W'(dec_op8);
   assign dec_ri = (RI_EN != 0) && dec_ri_raw;

   // per-stage next-value source: decode for stage 0, previous stage otherwise
   always_comb begin
      op_in    = '0;
      ri_in    = '0;
      md_in    = '0;
      bubble   = '0;
      op_in[0] = dec_op;
      ri_in[0] = dec_ri;
      md_in[0] = dec_md;
      for (int k = 1; k < STAGES; k++) begin
         op_in[k]  = op_q[k-1];
         ri_in[k]  = ri_q[k-1];
         md_in[k]  = md_q[k-1];
         bubble[k] = bus.stall[k-1];
      end
   end

   // stage registers: reset, then flush, then hold, then bubble, then advance
   always_ff @(posedge clk) begin
      for (int k = 0; k < STAGES; k++) begin
         if (rst || bus.flush[k]) begin
            op_q[k] <= '0;
            ri_q[k] <= 1'b0;
            md_q[k] <= 1'b0;
         end else if (bus.stall[k]) begin
            op_q[k] <= op_q[k];
            ri_q[k] <= ri_q[k];
            md_q[k] <= md_q[k];
         end else if (bubble[k]) begin
            op_q[k] <= '0;
            ri_q[k] <= 1'b0;
            md_q[k] <= 1'b0;
         end else begin
            op_q[k] <= op_in[k];
            ri_q[k] <= ri_in[k];
            md_q[k] <= md_in[k];
         end
      end
   end

   // MD handshake state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // MD handshake next state and pulses; all quiet while reset is asserted
   always_comb begin
      state_d      = state_q;
      md_start     = 1'b0;
      md_cancel    = 1'b0;
      md_stall_req = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               md_start     = md_q[0] & ~bus.flush[0];
               md_stall_req = md_start;
               if (md_start) state_d = BUSY;
            end
            BUSY: begin
               md_stall_req = ~bus.md_done;
               if (bus.flush[0]) begin
                  md_cancel = 1'b1;
                  state_d   = IDLE;
               end else if (bus.md_done) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.aluop_out    = op_q;
   assign bus.ri_out       = ri_q;
   assign bus.md_start     = md_start;
   assign bus.md_cancel    = md_cancel;
   assign bus.md_stall_req = md_stall_req;

endmodule
